// File: rtl/canny_pkg.sv
// Shared types and constants for the Canny edge pipeline stages.
package canny_pkg;

    localparam int unsigned PIX_W    = 8;
    localparam int unsigned ROWS     = 7;
    localparam int unsigned OUT_ROWS = ROWS - 2;
    localparam int unsigned GRAD_W   = 11;
    localparam int unsigned MAG_W    = 8;

    typedef logic [PIX_W-1:0]          pix_t;
    typedef logic signed [GRAD_W-1:0]  grad_t;

    typedef enum logic [1:0] {DIR_0, DIR_45, DIR_90, DIR_135} dir_t;
    typedef enum logic [1:0] {EMPTY, ONE, TWO, FULL} fill_t;

    // |g| always fits one bit narrower: gradients never reach -1024.
    function automatic logic [GRAD_W-2:0] abs_grad(input grad_t g);
        grad_t neg;
        neg = -g;
        return g[GRAD_W-1] ? neg[GRAD_W-2:0] : g[GRAD_W-2:0];
    endfunction

endpackage

// File: rtl/sobel_pe.sv
// One row of the Sobel stage: Gx/Gy register (stage 1), magnitude/direction register (stage 2).
// SOBEL_LOW_THRESH_EN adds low_thresh_i, zeroing weak magnitudes.
module sobel_pe
    import canny_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             s1_en_i,
    input  logic             s2_en_i,
    input  pix_t             col0_i [3],
    input  pix_t             col1_i [3],
    input  pix_t             col2_i [3],
`ifdef SOBEL_LOW_THRESH_EN
    input  logic [MAG_W-1:0] low_thresh_i,
`endif
    output logic [MAG_W-1:0] mag_o,
    output logic [1:0]       dir_o
);

    logic [9:0]  sum_l, sum_r, sum_t, sum_b;
    grad_t       gx_d, gy_d, gx_q, gy_q;
    logic [9:0]  ax, ay;
    logic [10:0] sum_mag;
    logic [12:0] ax2, ay2, ax5, ay5;
    logic [MAG_W-1:0] mag_d, mag_q;
    dir_t        dir_d, dir_q;

    always_comb begin
        sum_l = {2'b0, col0_i[0]} + {1'b0, col0_i[1], 1'b0} + {2'b0, col0_i[2]};
        sum_r = {2'b0, col2_i[0]} + {1'b0, col2_i[1], 1'b0} + {2'b0, col2_i[2]};
        sum_t = {2'b0, col0_i[0]} + {1'b0, col1_i[0], 1'b0} + {2'b0, col2_i[0]};
        sum_b = {2'b0, col0_i[2]} + {1'b0, col1_i[2], 1'b0} + {2'b0, col2_i[2]};
        gx_d  = $signed({1'b0, sum_r}) - $signed({1'b0, sum_l});
        gy_d  = $signed({1'b0, sum_b}) - $signed({1'b0, sum_t});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gx_q <= '0;
            gy_q <= '0;
        end else if (s1_en_i) begin
            gx_q <= gx_d;
            gy_q <= gy_d;
        end
    end

    always_comb begin
        ax      = abs_grad(gx_q);
        ay      = abs_grad(gy_q);
        sum_mag = {1'b0, ax} + {1'b0, ay};
        ax2     = {2'b0, ax, 1'b0};
        ay2     = {2'b0, ay, 1'b0};
        ax5     = ({3'b0, ax} << 2) + {3'b0, ax};
        ay5     = ({3'b0, ay} << 2) + {3'b0, ay};
        mag_d   = (|sum_mag[10:8]) ? 8'hFF : sum_mag[7:0];

        // Near-horizontal / near-vertical bands use tan(22.5deg) ~ 2/5.
        if (ax == '0 && ay == '0) begin
            dir_d = DIR_0;
        end else if (ay5 < ax2) begin
            dir_d = DIR_0;
        end else if (ax5 < ay2) begin
            dir_d = DIR_90;
        end else if (gx_q[GRAD_W-1] == gy_q[GRAD_W-1]) begin
            dir_d = DIR_45;
        end else begin
            dir_d = DIR_135;
        end

`ifdef SOBEL_LOW_THRESH_EN
        if (mag_d < low_thresh_i) begin
            mag_d = '0;
            dir_d = DIR_0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q <= '0;
            dir_q <= DIR_0;
        end else if (s2_en_i) begin
            mag_q <= mag_d;
            dir_q <= dir_d;
        end
    end

    assign mag_o = mag_q;
    assign dir_o = dir_q;

endmodule

// File: rtl/sobel_grad_block.sv
// Sobel gradient stage: 3-column sliding window over 7-pixel columns, 5 row PEs, 2-cycle latency.
// Optional SOBEL_LOW_THRESH_EN adds the low_thresh input.
module sobel_grad_block
    import canny_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic             col_valid,
    input  pix_t             col_in [ROWS],
`ifdef SOBEL_LOW_THRESH_EN
    input  logic [MAG_W-1:0] low_thresh,
`endif
    output logic [MAG_W-1:0] mag_out [OUT_ROWS],
    output logic [1:0]       dir_out [OUT_ROWS],
    output logic             out_valid
);

    fill_t fill_q, fill_d;
    pix_t  c0_q [ROWS];
    pix_t  c1_q [ROWS];
    pix_t  c2_q [ROWS];
    logic  fire;
    logic  v1_q, v2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q <= EMPTY;
        end else begin
            fill_q <= fill_d;
        end
    end

    always_comb begin
        fill_d = fill_q;
        fire   = 1'b0;
        if (frame_start) begin
            fill_d = col_valid ? ONE : EMPTY;
        end else if (col_valid) begin
            unique case (fill_q)
                EMPTY:     fill_d = ONE;
                ONE:       fill_d = TWO;
                TWO, FULL: begin
                    fill_d = FULL;
                    fire   = 1'b1;
                end
                default:   fill_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c0_q <= '{default: '0};
            c1_q <= '{default: '0};
            c2_q <= '{default: '0};
        end else if (frame_start) begin
            c0_q <= '{default: '0};
            c1_q <= '{default: '0};
            c2_q <= col_valid ? col_in : '{default: '0};
        end else if (col_valid) begin
            c0_q <= c1_q;
            c1_q <= c2_q;
            c2_q <= col_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= fire;
            v2_q <= v1_q;
        end
    end

    assign out_valid = v2_q;

    // Stage 1 samples the post-shift window: {c1_q, c2_q, col_in}.
    for (genvar k = 0; k < OUT_ROWS; k++) begin : g_pe
        pix_t w0 [3];
        pix_t w1 [3];
        pix_t w2 [3];

        for (genvar j = 0; j < 3; j++) begin : g_tap
            assign w0[j] = c1_q[k+j];
            assign w1[j] = c2_q[k+j];
            assign w2[j] = col_in[k+j];
        end

        sobel_pe u_pe (
            .clk          (clk),
            .rst          (rst),
            .s1_en_i      (fire),
            .s2_en_i      (v1_q),
            .col0_i       (w0),
            .col1_i       (w1),
            .col2_i       (w2),
`ifdef SOBEL_LOW_THRESH_EN
            .low_thresh_i (low_thresh),
`endif
            .mag_o        (mag_out[k]),
            .dir_o        (dir_out[k])
        );
    end

endmodule
